alu_op_sequencer: RTL and testbench

- Upstream control stage for the combinational Z8 ALU: fetches register operands, drives ALU mode/operands/flags, captures results and writes back to the register file.
- Sequences multi-pass operations (INCW/DECW word ops as two byte passes, DA as low/high nibble passes).
- Owns the architectural FLAGS register.
- Sits between the instruction decoder and the register file; the ALU instance lives beside it.

---
 rtl/alu_op_sequencer_if.sv | 33 +++
 rtl/alu_op_sequencer.sv | 125 ++++++++++++
 tb/tb_alu_op_sequencer.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/alu_op_sequencer_if.sv
// alu_op_sequencer_if: decoder command, register-file port, ALU port and FLAGS access of the op sequencer.
interface alu_op_sequencer_if;
   logic       start;
   logic [1:0] op;
   logic [4:0] mode;
   logic       wb;
   logic [7:0] addr;
   logic [7:0] bOperand;
   logic       rfRe;
   logic [7:0] rfAddr;
   logic [7:0] rfRdata;
   logic       rfWe;
   logic [7:0] rfWdata;
   logic [4:0] aluMode;
   logic [7:0] aluA;
   logic [7:0] aluB;
   logic [7:0] aluFlags;
   logic [7:0] aluOut;
   logic [7:0] aluOutFlags;
   logic       flagsWe;
   logic [7:0] flagsWdata;
   logic [7:0] flags;
   logic       busy;
   logic       done;
   modport master (
      input  start, op, mode, wb, addr, bOperand, rfRdata, aluOut, aluOutFlags, flagsWe, flagsWdata,
      output rfRe, rfAddr, rfWe, rfWdata, aluMode, aluA, aluB, aluFlags, flags, busy, done
   );
   modport slave (
      output start, op, mode, wb, addr, bOperand, rfRdata, aluOut, aluOutFlags, flagsWe, flagsWdata,
      input  rfRe, rfAddr, rfWe, rfWdata, aluMode, aluA, aluB, aluFlags, flags, busy, done
   );
endinterface

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: fetches operands, drives the Z8 ALU, writes results back and owns FLAGS (C Z S V D H F2 F1).
module alu_op_sequencer #(
   parameter logic [7:0] FLAGS_RESET = 8'h00,
   parameter logic [4:0] MODE_LD     = 5'h00,
   parameter logic [4:0] MODE_INC    = 5'h10,
   parameter logic [4:0] MODE_DEC    = 5'h11,
   parameter logic [4:0] MODE_INCW   = 5'h12,
   parameter logic [4:0] MODE_DECW   = 5'h13,
   parameter logic [4:0] MODE_DA     = 5'h14,
   parameter logic [4:0] MODE_DA_H   = 5'h15
) (
   input logic                clk,
   input logic                reset_n,
   alu_op_sequencer_if.master bus
);
   localparam logic [1:0] OP_BYTE = 2'd0, OP_INCW = 2'd1, OP_DECW = 2'd2, OP_DA = 2'd3;
   typedef enum logic [3:0] {IDLE, RD, EX, WB, RD_LO, EX_LO, WR_LO, RD_HI, EX_HI, WR_HI, P1, P2} state_t;
   state_t     state_q;
   logic [1:0] op_q;
   logic [4:0] mode_q;
   logic       wb_q;
   logic [7:0] addr_q;
   logic [7:0] b_q;
   logic [7:0] res_q;
   logic [7:0] fl_q;
   logic [7:0] flags_q;
   logic [7:0] flags_d;
   logic       re_q;
   logic       we_q;
   logic       done_q;
   logic       busy_q;
   logic [7:0] da_res;
   logic       flag_upd;
   assign da_res   = {bus.aluOut[7:4], res_q[3:0]};
   assign flag_upd = state_q inside {WB, WR_HI};
   // a sequencer flag write-back beats an external FLAGS load in the same cycle
   assign flags_d  = flag_upd ? fl_q : bus.flagsWe ? bus.flagsWdata : flags_q;
   assign bus.rfAddr  = state_q inside {RD_LO, EX_LO, WR_LO} ? {addr_q[7:1], 1'b1} :
                        state_q inside {RD_HI, EX_HI, WR_HI} ? {addr_q[7:1], 1'b0} : addr_q;
   assign bus.aluMode = state_q == EX    ? mode_q :
                        state_q == EX_LO ? (op_q == OP_INCW ? MODE_INC : MODE_DEC) :
                        state_q == EX_HI ? (op_q == OP_INCW ? MODE_INCW : MODE_DECW) :
                        state_q == P1    ? MODE_DA :
                        state_q == P2    ? MODE_DA_H : MODE_LD;
   assign bus.aluA     = state_q inside {EX, EX_LO, EX_HI, P1} ? bus.rfRdata : state_q == P2 ? res_q : 8'h00;
   assign bus.aluB     = state_q == EX ? b_q : state_q == EX_HI ? res_q : 8'h00;
   assign bus.aluFlags = flags_q;
   assign bus.flags    = flags_q;
   assign bus.rfWdata  = res_q;
   assign bus.rfRe     = re_q;
   assign bus.rfWe     = we_q;
   assign bus.done     = done_q;
   assign bus.busy     = busy_q;
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         op_q    <= OP_BYTE;
         mode_q  <= 5'h00;
         wb_q    <= 1'b0;
         addr_q  <= 8'h00;
         b_q     <= 8'h00;
         res_q   <= 8'h00;
         fl_q    <= 8'h00;
         flags_q <= FLAGS_RESET;
         re_q    <= 1'b0;
         we_q    <= 1'b0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         flags_q <= flags_d;
         re_q    <= 1'b0;
         we_q    <= 1'b0;
         done_q  <= 1'b0;
         case (state_q)
            IDLE: if (bus.start) begin
               op_q    <= bus.op;
               mode_q  <= bus.mode;
               wb_q    <= bus.op == OP_BYTE ? bus.wb : 1'b1;
               addr_q  <= bus.addr;
               b_q     <= bus.bOperand;
               state_q <= bus.op inside {OP_INCW, OP_DECW} ? RD_LO : RD;
               re_q    <= 1'b1;
               busy_q  <= 1'b1;
            end
            RD:    state_q <= op_q == OP_DA ? P1 : EX;
            EX, EX_HI: begin
               res_q   <= bus.aluOut;
               fl_q    <= bus.aluOutFlags;
               state_q <= state_q == EX ? WB : WR_HI;
               we_q    <= wb_q;
               done_q  <= 1'b1;
            end
            RD_LO: state_q <= EX_LO;
            EX_LO: begin
               res_q   <= bus.aluOut;
               state_q <= WR_LO;
               we_q    <= 1'b1;
            end
            WR_LO: begin
               state_q <= RD_HI;
               re_q    <= 1'b1;
            end
            RD_HI: state_q <= EX_HI;
            P1: begin
               res_q   <= bus.aluOut;
               fl_q    <= bus.aluOutFlags;
               state_q <= P2;
            end
            // Z and S must describe the merged nibbles, not the DA_H pass alone
            P2: begin
               res_q   <= da_res;
               fl_q    <= {bus.aluOutFlags[7], da_res == 8'h00, da_res[7], bus.aluOutFlags[4:0]};
               state_q <= WB;
               we_q    <= wb_q;
               done_q  <= 1'b1;
            end
            WB, WR_HI: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: directed vectors against a register-file and Z8 ALU model beside the sequencer.
module tb_alu_op_sequencer;
   localparam logic [1:0] OP_BYTE = 2'd0, OP_INCW = 2'd1, OP_DECW = 2'd2, OP_DA = 2'd3;
   localparam logic [4:0] M_LD = 5'h00, M_ADD = 5'h01, M_CP = 5'h05, M_INC = 5'h10, M_DEC = 5'h11;
   localparam logic [4:0] M_INCW = 5'h12, M_DECW = 5'h13, M_DA = 5'h14, M_DA_H = 5'h15;
   logic       clk = 1'b0;
   logic       reset_n = 1'b1;
   logic [7:0] rf [256];
   logic       pl_we;
   logic [7:0] pl_addr;
   logic [7:0] pl_data;
   logic [8:0] sum;
   logic [4:0] nib;
   logic       adj;
   int         n_chk = 0;
   int         n_pass = 0;
   int         nb, nd, nw, fw, lw;
   alu_op_sequencer_if bus ();
   alu_op_sequencer dut (.clk(clk), .reset_n(reset_n), .bus(bus));
   initial forever #5 clk = ~clk;
   always @(posedge clk) begin
      if (bus.rfWe) rf[bus.rfAddr] <= bus.rfWdata;
      else if (pl_we) rf[pl_addr] <= pl_data;
      if (bus.rfRe) bus.rfRdata <= rf[bus.rfAddr];
   end
   always_comb begin
      sum = 9'h000;
      nib = 5'h00;
      adj = 1'b0;
      bus.aluOut = bus.aluA;
      bus.aluOutFlags = bus.aluFlags;
      case (bus.aluMode)
         M_ADD: begin
            sum = {1'b0, bus.aluA} + {1'b0, bus.aluB};
            nib = {1'b0, bus.aluA[3:0]} + {1'b0, bus.aluB[3:0]};
            bus.aluOut = sum[7:0];
            bus.aluOutFlags = {sum[8], sum[7:0] == 8'h00, sum[7],
                               bus.aluA[7] == bus.aluB[7] && sum[7] != bus.aluA[7], 1'b0, nib[4], bus.aluFlags[1:0]};
         end
         M_CP: begin
            sum = {1'b0, bus.aluA} - {1'b0, bus.aluB};
            bus.aluOut = sum[7:0];
            bus.aluOutFlags = {sum[8], sum[7:0] == 8'h00, sum[7],
                               bus.aluA[7] != bus.aluB[7] && sum[7] != bus.aluA[7], bus.aluFlags[3:0]};
         end
         M_INC: begin
            bus.aluOut = bus.aluA + 8'h01;
            bus.aluOutFlags = {bus.aluFlags[7], bus.aluOut == 8'h00, bus.aluOut[7], bus.aluA == 8'h7F, bus.aluFlags[3:0]};
         end
         M_DEC: begin
            bus.aluOut = bus.aluA - 8'h01;
            bus.aluOutFlags = {bus.aluFlags[7], bus.aluOut == 8'h00, bus.aluOut[7], bus.aluA == 8'h80, bus.aluFlags[3:0]};
         end
         M_INCW: begin
            bus.aluOut = bus.aluA + {7'h00, bus.aluB == 8'h00};
            bus.aluOutFlags = {bus.aluFlags[7], bus.aluOut == 8'h00 && bus.aluB == 8'h00, bus.aluOut[7],
                               bus.aluA == 8'h7F && bus.aluB == 8'h00, bus.aluFlags[3:0]};
         end
         M_DECW: begin
            bus.aluOut = bus.aluA - {7'h00, bus.aluB == 8'hFF};
            bus.aluOutFlags = {bus.aluFlags[7], bus.aluOut == 8'h00 && bus.aluB == 8'h00, bus.aluOut[7],
                               bus.aluA == 8'h80 && bus.aluB == 8'hFF, bus.aluFlags[3:0]};
         end
         M_DA: begin
            adj = bus.aluA[3:0] > 4'h9 || bus.aluFlags[2];
            bus.aluOut = adj ? bus.aluA + 8'h06 : bus.aluA;
            bus.aluOutFlags = {bus.aluFlags[7], bus.aluOut == 8'h00, bus.aluOut[7], bus.aluFlags[4:0]};
         end
         M_DA_H: begin
            adj = bus.aluA[7:4] > 4'h9 || bus.aluFlags[7];
            bus.aluOut = adj ? bus.aluA + 8'h60 : bus.aluA;
            bus.aluOutFlags = {adj, bus.aluOut == 8'h00, bus.aluOut[7], bus.aluFlags[4:0]};
         end
         default: ;
      endcase
   end
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask
   task automatic poke(input logic [7:0] a, input logic [7:0] d);
      pl_addr = a;
      pl_data = d;
      pl_we = 1'b1;
      @(posedge clk); #1;
      pl_we = 1'b0;
   endtask
   // start stays high through the first busy cycle; fk raises flagsWe=FF at that cycle index
   task automatic run(input logic [1:0] o, input logic [4:0] m, input logic w, input logic [7:0] a,
                      input logic [7:0] b, input int fk, output int rb, output int rd, output int rw,
                      output int rf_first, output int rf_last);
      bus.op = o;
      bus.mode = m;
      bus.wb = w;
      bus.addr = a;
      bus.bOperand = b;
      bus.start = 1'b1;
      rb = 0; rd = 0; rw = 0; rf_first = 0; rf_last = 0;
      for (int k = 1; k <= 12; k++) begin
         @(posedge clk); #1;
         if (k == 2) bus.start = 1'b0;
         if (k == fk) begin
            bus.flagsWe = 1'b1;
            bus.flagsWdata = 8'hFF;
         end
         if (!bus.busy) break;
         rb++;
         rd += int'(bus.done);
         if (bus.rfWe) begin
            rw++;
            if (rf_first == 0) rf_first = k;
            rf_last = k;
         end
      end
      bus.start = 1'b0;
      chk("op_finished", bus.busy, 0);
   endtask
   initial begin
      bus.start = 1'b0; bus.op = 2'd0; bus.mode = 5'h00; bus.wb = 1'b0; bus.addr = 8'h00;
      bus.bOperand = 8'h00; bus.flagsWe = 1'b0; bus.flagsWdata = 8'h00;
      pl_we = 1'b0; pl_addr = 8'h00; pl_data = 8'h00;
      #2 reset_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_flags", bus.flags, 8'h00);
      chk("rst_ctl", {bus.busy, bus.done, bus.rfRe, bus.rfWe}, 4'b0000);
      reset_n = 1'b1;
      poke(8'h10, 8'h3C); poke(8'h20, 8'h12); poke(8'h21, 8'hFF); poke(8'h30, 8'h00); poke(8'h31, 8'h00);
      poke(8'h40, 8'h9A); poke(8'h41, 8'h15); poke(8'h50, 8'h05); poke(8'h60, 8'hAA); poke(8'h61, 8'hFF);
      poke(8'h70, 8'h7F);
      run(OP_BYTE, M_ADD, 1'b1, 8'h10, 8'hC4, 0, nb, nd, nw, fw, lw);
      chk("add_res", rf[8'h10], 8'h00);
      chk("add_flags", bus.flags, 8'hC4);
      chk("add_busy", nb, 3);
      chk("add_done", nd, 1);
      chk("add_wecyc", fw, 3);
      run(OP_INCW, M_LD, 1'b0, 8'h21, 8'h00, 0, nb, nd, nw, fw, lw);
      chk("incw_lo", rf[8'h21], 8'h00);
      chk("incw_hi", rf[8'h20], 8'h13);
      chk("incw_zs", bus.flags[6:5], 2'b00);
      chk("incw_we1", fw, 3);
      chk("incw_we2", lw, 6);
      chk("incw_nwe", nw, 2);
      chk("incw_done", nd, 1);
      run(OP_DECW, M_LD, 1'b0, 8'h30, 8'h00, 0, nb, nd, nw, fw, lw);
      chk("decw_lo", rf[8'h31], 8'hFF);
      chk("decw_hi", rf[8'h30], 8'hFF);
      chk("decw_zs", bus.flags[6:5], 2'b01);
      bus.flagsWe = 1'b1;
      bus.flagsWdata = 8'h00;
      @(posedge clk); #1;
      bus.flagsWe = 1'b0;
      chk("ld_flags", bus.flags, 8'h00);
      run(OP_DA, M_LD, 1'b0, 8'h40, 8'h00, 0, nb, nd, nw, fw, lw);
      chk("da_res", rf[8'h40], 8'h00);
      chk("da_flags", bus.flags, 8'hC0);
      chk("da_busy", nb, 4);
      chk("da_nwe", nw, 1);
      run(OP_DA, M_LD, 1'b0, 8'h41, 8'h00, 0, nb, nd, nw, fw, lw);
      chk("da_c_res", rf[8'h41], 8'h75);
      chk("da_c_flags", bus.flags, 8'h80);
      run(OP_BYTE, M_CP, 1'b0, 8'h50, 8'h05, 3, nb, nd, nw, fw, lw);
      chk("cp_nwe", nw, 0);
      chk("cp_reg", rf[8'h50], 8'h05);
      chk("cp_flags", bus.flags, 8'h40);
      @(posedge clk); #1;
      bus.flagsWe = 1'b0;
      chk("cp_ext_flags", bus.flags, 8'hFF);
      bus.op = OP_INCW;
      bus.addr = 8'h60;
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk("exhi_mode", bus.aluMode, M_INCW);
      reset_n = 1'b0;
      #1;
      chk("abort_flags", bus.flags, 8'h00);
      chk("abort_ctl", {bus.busy, bus.done, bus.rfWe}, 3'b000);
      @(posedge clk); #1;
      reset_n = 1'b1;
      chk("abort_lo", rf[8'h61], 8'h00);
      chk("abort_hi", rf[8'h60], 8'hAA);
      run(OP_BYTE, M_ADD, 1'b1, 8'h70, 8'h01, 0, nb, nd, nw, fw, lw);
      chk("post_res", rf[8'h70], 8'h80);
      chk("post_flags", bus.flags, 8'h34);
      chk("post_busy", nb, 3);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
